// File: rtl/reg_file_2r1w_dump_pkg.sv
// Shared definitions for the 2-read/1-write register file with debug dump.
package reg_file_2r1w_dump_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_AW    = 5;

    // Dump sequencer states: IDLE waits for a request, SEND streams elements.
    typedef enum logic {
        RF_S_IDLE = 1'b0,
        RF_S_SEND = 1'b1
    } rf_state_e;

endpackage : reg_file_2r1w_dump_pkg

// File: rtl/reg_file_2r1w_dump_fsm.sv
// Debug-dump sequencer: walks register indices 0..DEPTH-1 over a valid/ready
// handshake and tells the storage side when and which register to snapshot.
module rf_dump_fsm
    import reg_file_2r1w_dump_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_ready,
    output logic          o_busy,
    output logic          o_valid,
    output logic [AW-1:0] o_idx,
    output logic          o_capture,
    output logic [AW-1:0] o_cap_idx
);

    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;

    // State and index registers; reset returns straight to IDLE at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RF_S_IDLE;
            r_idx   <= IDX_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state, next index and snapshot request for the data register.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        o_capture   = 1'b0;
        o_cap_idx   = IDX_ZERO;
        case (r_state)
            RF_S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = RF_S_SEND;
                    w_idx_nxt   = IDX_ZERO;
                    o_capture   = 1'b1;
                    o_cap_idx   = IDX_ZERO;
                end else begin
                    w_state_nxt = RF_S_IDLE;
                end
            end
            RF_S_SEND: begin
                // Start requests are ignored here: a dump is never restarted.
                if (i_ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = RF_S_IDLE;
                        w_idx_nxt   = IDX_ZERO;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_ONE;
                        o_capture   = 1'b1;
                        o_cap_idx   = r_idx + IDX_ONE;
                    end
                end else begin
                    w_state_nxt = RF_S_SEND;
                end
            end
            default: begin
                w_state_nxt = RF_S_IDLE;
                w_idx_nxt   = IDX_ZERO;
            end
        endcase
    end

    // Outputs are direct decodes of registered state, so they are glitch-free.
    assign o_valid = (r_state == RF_S_SEND);
    assign o_busy  = (r_state == RF_S_SEND);
    assign o_idx   = r_idx;

endmodule : rf_dump_fsm

// File: rtl/reg_file_2r1w_dump.sv
// CPU register file: one synchronous write port, two combinational read ports
// with same-cycle write-through bypass, plus a streaming debug-dump reader.
module reg_file_2r1w_dump
    import reg_file_2r1w_dump_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int AW       = RF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             We,
    input  logic [AW-1:0]    Wn,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    Rna,
    output logic [WIDTH-1:0] Qa,
    input  logic [AW-1:0]    Rnb,
    output logic [WIDTH-1:0] Qb,
    input  logic             Dump_start,
    output logic             Dump_busy,
    output logic             Dump_valid,
    input  logic             Dump_ready,
    output logic [AW-1:0]    Dump_idx,
    output logic [WIDTH-1:0] Dump_data
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic          HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_regs [0:DEPTH-1];
    logic [WIDTH-1:0] r_dump_data;
    logic             w_wr_en;
    logic             w_capture;
    logic [AW-1:0]    w_cap_idx;
    logic [WIDTH-1:0] w_cap_val;
    logic [WIDTH-1:0] w_qa;
    logic [WIDTH-1:0] w_qb;

    // A write to r0 is dropped when r0 is hard-wired to zero.
    assign w_wr_en = We && !(HAS_ZERO && (Wn == IDX_ZERO));

    // Storage array: cleared by reset, updated on enabled writes.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_regs[Wn] <= D;
        end
    end

    // Read port A: zero register, then write-through bypass, then storage.
    always_comb begin
        w_qa = {WIDTH{1'b0}};
        if (HAS_ZERO && (Rna == IDX_ZERO)) begin
            w_qa = {WIDTH{1'b0}};
        end else if (We && (Wn == Rna)) begin
            w_qa = D;
        end else begin
            w_qa = r_regs[Rna];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        w_qb = {WIDTH{1'b0}};
        if (HAS_ZERO && (Rnb == IDX_ZERO)) begin
            w_qb = {WIDTH{1'b0}};
        end else if (We && (Wn == Rnb)) begin
            w_qb = D;
        end else begin
            w_qb = r_regs[Rnb];
        end
    end

    // Dump snapshot source: same bypassed read, so a write landing on the
    // captured register in the capture cycle is seen as the new value.
    always_comb begin
        w_cap_val = {WIDTH{1'b0}};
        if (HAS_ZERO && (w_cap_idx == IDX_ZERO)) begin
            w_cap_val = {WIDTH{1'b0}};
        end else if (We && (Wn == w_cap_idx)) begin
            w_cap_val = D;
        end else begin
            w_cap_val = r_regs[w_cap_idx];
        end
    end

    // Held dump element: only changes on a capture, so later writes to the
    // register being offered do not disturb it.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_dump_data <= {WIDTH{1'b0}};
        end else if (w_capture) begin
            r_dump_data <= w_cap_val;
        end
    end

    rf_dump_fsm #(
        .AW (AW)
    ) u_dump_fsm (
        .clk       (Clk),
        .rst_n     (Clrn),
        .i_start   (Dump_start),
        .i_ready   (Dump_ready),
        .o_busy    (Dump_busy),
        .o_valid   (Dump_valid),
        .o_idx     (Dump_idx),
        .o_capture (w_capture),
        .o_cap_idx (w_cap_idx)
    );

    assign Qa        = w_qa;
    assign Qb        = w_qb;
    assign Dump_data = r_dump_data;

endmodule : reg_file_2r1w_dump
